// File: rtl/apb4_modport_slave_if.sv
// APB4 bus bundle between the config-register master and its target.
// Clock and reset stay outside so both sides share plain scalar ports.
interface apb4_modport_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_modport_slave.sv
// APB4 target serving a bank of 32-bit config registers with ID at 0x00,
// byte strobes, wait states and error response.
module apb4_modport_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B4_0001
) (
  input  logic                           pclk,
  input  logic                           presetn,
  apb4_modport_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [1:0]                     apb_state
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d, phase;
  logic [3:0] wait_q, wait_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [IW-1:0] idx;
  logic viol, acc, done, err;

  // state_q is the phase context left by the previous cycle;
  // phase is the bus phase of the current cycle.
  always_comb begin
    phase = IDLE;
    viol  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) phase = SETUP;
        else if (bus.psel)            viol  = 1'b1;
      end
      SETUP, ACCESS: begin
        if (bus.psel) phase = bus.penable ? ACCESS : SETUP;
      end
      default: phase = IDLE;
    endcase
  end

  always_comb begin
    idx  = bus.paddr[IW+1:2];
    err  = (bus.paddr[1:0] != 2'b00)
         || (bus.paddr >= LIMIT)
         || (bus.pwrite && bus.paddr == '0);
    acc  = (phase == ACCESS);
    done = acc && (wait_q == WS);
    state_d = done ? IDLE : phase;
    wait_d  = (acc && !done) ? wait_q + 4'd1 : 4'd0;
    regs_d  = regs_q;
    if (done && bus.pwrite && !err) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.pstrb[k]) regs_d[idx][8*k+:8] = bus.pwdata[8*k+:8];
      end
    end
    regs_d[0] = ID_VALUE;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      regs_q    <= '0;
      regs_q[0] <= ID_VALUE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      regs_q  <= regs_d;
    end
  end

  // Reset masks every bus response so a half-done transfer is invisible.
  always_comb begin
    bus.pready  = presetn && (done || viol);
    bus.pslverr = presetn && (viol || (done && err));
    bus.prdata  = '0;
    if (presetn && done && !bus.pwrite && !err) bus.prdata = regs_q[idx];
    apb_state = presetn ? phase : IDLE;
  end

  assign regs_o = regs_q;

endmodule

// File: tb/tb_apb4_modport_slave.sv
// Directed bench for apb4_modport_slave: one zero-wait and one
// three-wait instance on a shared clock and reset.
module tb_apb4_modport_slave;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb4_modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb4_modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  logic [511:0] regs0, regs3;
  logic [1:0]   st0, st3;

  apb4_modport_slave #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(b0),
    .regs_o(regs0), .apb_state(st0)
  );

  apb4_modport_slave #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .bus(b3),
    .regs_o(regs3), .apb_state(st3)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m [16];

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mvec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32+:32] = m[i];
    return v;
  endfunction

  task automatic idle_bus();
    b0.psel = 0; b0.penable = 0; b0.pwrite = 0;
    b0.paddr = '0; b0.pwdata = '0; b0.pstrb = '0;
    b3.psel = 0; b3.penable = 0; b3.pwrite = 0;
    b3.paddr = '0; b3.pwdata = '0; b3.pstrb = '0;
  endtask

  task automatic xfer(input string tag, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s,
                      input logic [31:0] exp_rd, input bit exp_err);
    int n;
    @(posedge pclk); #1;
    b0.psel = 1; b0.penable = 0; b0.pwrite = wr;
    b0.paddr = a; b0.pwdata = d; b0.pstrb = s;
    @(posedge pclk); #1;
    b0.penable = 1;
    n = 0;
    @(negedge pclk);
    while (!b0.pready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk({tag, "_lat"}, 512'(n), 512'(0));
    chk({tag, "_err"}, 512'(b0.pslverr), 512'(exp_err));
    if (!wr) chk({tag, "_rd"}, 512'(b0.prdata), 512'(exp_rd));
    @(posedge pclk); #1;
    b0.psel = 0; b0.penable = 0;
  endtask

  initial begin
    idle_bus();
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0] = 32'hA5B4_0001;
    repeat (2) @(posedge pclk);
    #1 presetn = 1;
    @(negedge pclk);
    chk("rst_prdata", 512'(b0.prdata), 512'(0));
    chk("rst_pready", 512'(b0.pready), 512'(0));
    chk("rst_pslverr", 512'(b0.pslverr), 512'(0));
    chk("rst_state", 512'(st0), 512'(0));
    chk("rst_regs0", regs0, mvec());
    chk("rst_regs3", regs3, mvec());

    xfer("rd_id", 0, 32'h00, 0, 0, 32'hA5B4_0001, 0);
    xfer("rd_r1", 0, 32'h04, 0, 0, 32'h0, 0);

    xfer("wr_full", 1, 32'h08, 32'hDEADBEEF, 4'b1111, 0, 0);
    m[2] = 32'hDEADBEEF;
    xfer("rd_full", 0, 32'h08, 0, 0, 32'hDEADBEEF, 0);
    xfer("wr_part", 1, 32'h08, 32'h11223344, 4'b0101, 0, 0);
    m[2] = 32'hDE22BE44;
    xfer("rd_part", 0, 32'h08, 0, 0, 32'hDE22BE44, 0);
    xfer("wr_nostrb", 1, 32'h08, 32'hFFFFFFFF, 4'b0000, 0, 0);
    xfer("wr_last", 1, 32'h3C, 32'hCAFEF00D, 4'b1111, 0, 0);
    m[15] = 32'hCAFEF00D;
    xfer("rd_last", 0, 32'h3C, 0, 0, 32'hCAFEF00D, 0);
    @(negedge pclk);
    chk("regs_after_wr", regs0, mvec());

    xfer("wr_id", 1, 32'h00, 32'h12345678, 4'b1111, 0, 1);
    xfer("wr_oor", 1, 32'h40, 32'h12345678, 4'b1111, 0, 1);
    xfer("wr_mis", 1, 32'h06, 32'h12345678, 4'b1111, 0, 1);
    xfer("rd_mis", 0, 32'h06, 0, 0, 32'h0, 1);
    xfer("rd_oor", 0, 32'h40, 0, 0, 32'h0, 1);
    xfer("rd_id2", 0, 32'h00, 0, 0, 32'hA5B4_0001, 0);
    @(negedge pclk);
    chk("regs_after_err", regs0, mvec());

    // ACCESS straight out of IDLE
    @(posedge pclk); #1;
    b0.psel = 1; b0.penable = 1; b0.pwrite = 1;
    b0.paddr = 32'h04; b0.pwdata = 32'hFFFFFFFF; b0.pstrb = 4'hF;
    @(negedge pclk);
    chk("viol_pready", 512'(b0.pready), 512'(1));
    chk("viol_pslverr", 512'(b0.pslverr), 512'(1));
    chk("viol_state", 512'(st0), 512'(0));
    @(posedge pclk); #1;
    b0.psel = 0; b0.penable = 0;
    @(negedge pclk);
    chk("viol_regs", regs0, mvec());

    // three wait states on the second instance
    @(posedge pclk); #1;
    b3.psel = 1; b3.penable = 0; b3.pwrite = 0; b3.paddr = 32'h04;
    @(negedge pclk);
    chk("ws_setup_state", 512'(st3), 512'(1));
    chk("ws_setup_rdy", 512'(b3.pready), 512'(0));
    @(posedge pclk); #1;
    b3.penable = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk($sformatf("ws_acc%0d_state", i), 512'(st3), 512'(2));
      chk($sformatf("ws_acc%0d_rdy", i), 512'(b3.pready),
          512'(i == 3));
    end
    chk("ws_rd", 512'(b3.prdata), 512'(0));
    chk("ws_err", 512'(b3.pslverr), 512'(0));
    @(posedge pclk); #1;
    b3.psel = 0; b3.penable = 0;
    @(negedge pclk);
    chk("ws_end_state", 512'(st3), 512'(0));
    chk("ws_end_rdy", 512'(b3.pready), 512'(0));

    // reset lands on the ACCESS cycle of a write
    @(posedge pclk); #1;
    b0.psel = 1; b0.penable = 0; b0.pwrite = 1;
    b0.paddr = 32'h0C; b0.pwdata = 32'h55AA55AA; b0.pstrb = 4'hF;
    @(posedge pclk); #1;
    b0.penable = 1; presetn = 0;
    @(negedge pclk);
    chk("rstx_pready", 512'(b0.pready), 512'(0));
    chk("rstx_pslverr", 512'(b0.pslverr), 512'(0));
    chk("rstx_prdata", 512'(b0.prdata), 512'(0));
    chk("rstx_state", 512'(st0), 512'(0));
    @(posedge pclk); #1;
    b0.psel = 0; b0.penable = 0; presetn = 1;
    for (int i = 1; i < 16; i++) m[i] = '0;
    @(negedge pclk);
    chk("rstx_state2", 512'(st0), 512'(0));
    chk("rstx_regs", regs0, mvec());
    xfer("rstx_rd", 0, 32'h0C, 0, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
